id_ex_stage: RTL
================

// Module: id_ex_stage
// PURPOSE
//   ID/EX pipeline boundary directly downstream of the register file. Captures ReadData1/2, decoded
//   fields and control each cycle; bypasses the same-cycle WB write (regfile write lands on the edge,
//   so the ID read is stale); detects load-use hazards and injects bubbles; honours stall and flush.
// PARAMETERS
//   DATA_W  32  datapath width
//   REG_AW  5   register address width
//   CTRL_W  9   control bundle width (bit map in shared package)
// PORTS
//   clk           in   1       rising-edge clock
//   rst           in   1       asynchronous, active-low reset
//   id_rs         in   REG_AW  ReadReg1 address sent to register file
//   id_rt         in   REG_AW  ReadReg2 address
//   id_rd         in   REG_AW  rd field
//   id_imm16      in   16      immediate field
//   id_ctrl       in   CTRL_W  decoded control bundle
//   id_valid      in   1       ID holds a real instruction
//   rf_rdata1     in   DATA_W  register file ReadData1
//   rf_rdata2     in   DATA_W  register file ReadData2
//   wb_wreg       in   REG_AW  WB write address (also drives regfile WriteReg)
//   wb_wdata      in   DATA_W  WB write data
//   wb_we         in   1       WB RegWrite_ctrl
//   stall_in      in   1       external hold (e.g. memory wait)
//   flush_in      in   1       branch/jump squash
//   ex_rs/ex_rt/ex_rd  out REG_AW  registered addresses
//   ex_a/ex_b     out  DATA_W  registered operands after bypass
//   ex_imm        out  DATA_W  registered sign-extended immediate
//   ex_ctrl       out  CTRL_W  registered control
//   ex_valid      out  1       EX holds a real instruction
//   hz_stall      out  1       load-use hazard: IF and ID must hold this cycle
// BEHAVIOUR
//   - Reset (rst=0, async): all outputs 0; ex_ctrl=0 is a NOP (no write, no mem access).
//   - Bypass (comb): a = (wb_we && wb_wreg!=0 && wb_wreg==id_rs) ? wb_wdata : rf_rdata1; b likewise
//     on id_rt. Register 0 never bypassed; always reads 0.
//   - imm: {{(DATA_W-16){id_imm16[15]}}, id_imm16}.
//   - hz_stall (comb) = ex_valid && ex_ctrl[MEM_READ] && ex_rt!=0 && id_valid &&
//     (ex_rt==id_rs || (ex_rt==id_rt && id_ctrl[USES_RT])).
//   - Per clock edge, priority order:
//     1. flush_in : load bubble (ex_ctrl=0, ex_valid=0, data fields 0).
//     2. stall_in : hold all EX outputs unchanged; hz_stall still evaluated.
//     3. hz_stall : load bubble; upstream holds, instruction re-enters next cycle with new bypass.
//     4. else     : load bypassed operands, fields, id_ctrl&{CTRL_W{id_valid}}, ex_valid=id_valid.
//   - Latency: one cycle ID->EX. No state machine beyond this register; bubble count is implicit.
//   - flush_in with stall_in: flush wins. Reset mid-stall: outputs cleared immediately, no hold.
//   - Bypass applies during stall-release too: the held ID instruction re-reads each cycle.
//   - Load-use on ex_rt==0 never stalls; id_valid=0 never stalls.
// STRUCTURE
//   - Shared package mips_pipe_pkg: CTRL_W and bit indices REG_WRITE, MEM_READ, MEM_WRITE,
//     MEM_TO_REG, REG_DST, ALU_SRC, USES_RT, ALU_OP[1:0]; NOP_CTRL constant.
//   - One sub-module: id_bypass (2-operand WB->ID forwarding compare/mux), instantiated once.
//   - Pipeline register and hazard compare inline in id_ex_stage.
// TESTING
//   1. rst=0 mid-run with ex_valid=1 -> all outputs 0 within same cycle, no clock needed.
//   2. rf_rdata1=0x11, wb_we=1, wb_wreg=id_rs=5, wb_wdata=0xABCD -> next edge ex_a=0xABCD.
//   3. wb_we=1, wb_wreg=id_rs=0, wb_wdata=0xFFFF, rf_rdata1=0 -> ex_a=0.
//   4. EX holds lw (MEM_READ=1, ex_rt=8), ID add id_rs=8 -> hz_stall=1, next edge ex_valid=0,
//      ex_ctrl=0; following edge add loads, hz_stall=0.
//   5. stall_in=1 for 3 cycles with changing ID inputs -> EX outputs constant; then resume.
//   6. flush_in=1 and stall_in=1 together -> bubble loaded; id_imm16=0x8000 later -> ex_imm=0xFFFF8000.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Shared pipeline definitions.
// Control bundle bit map and the NOP encoding.
package mips_pipe_pkg;

   localparam int CTRL_W     = 9;

   localparam int REG_WRITE  = 0;
   localparam int MEM_READ   = 1;
   localparam int MEM_WRITE  = 2;
   localparam int MEM_TO_REG = 3;
   localparam int REG_DST    = 4;
   localparam int ALU_SRC    = 5;
   localparam int USES_RT    = 6;
   localparam int ALU_OP_LO  = 7;
   localparam int ALU_OP_HI  = 8;

   localparam logic [CTRL_W-1:0] NOP_CTRL = '0;

endpackage

// File: rtl/id_bypass.sv
// WB->ID forwarding for both register file read ports.
// The regfile write lands on the edge, so the same-cycle read is stale.
module id_bypass #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic [REG_AW-1:0] rs_i,
   input  logic [REG_AW-1:0] rt_i,
   input  logic [DATA_W-1:0] rdata1_i,
   input  logic [DATA_W-1:0] rdata2_i,
   input  logic [REG_AW-1:0] wb_wreg_i,
   input  logic [DATA_W-1:0] wb_wdata_i,
   input  logic              wb_we_i,
   output logic [DATA_W-1:0] a_o,
   output logic [DATA_W-1:0] b_o
);

   logic wb_live;
   logic hit_rs;
   logic hit_rt;

   assign wb_live = wb_we_i && (wb_wreg_i != '0);
   assign hit_rs  = wb_live && (wb_wreg_i == rs_i);
   assign hit_rt  = wb_live && (wb_wreg_i == rt_i);

   // Select the in-flight WB value over the stale regfile data.
   always_comb begin
      a_o = hit_rs ? wb_wdata_i : rdata1_i;
      b_o = hit_rt ? wb_wdata_i : rdata2_i;
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with WB bypass,
// load-use hazard detection, stall and flush.
module id_ex_stage #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int CTRL_W = mips_pipe_pkg::CTRL_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic [REG_AW-1:0] id_rd,
   input  logic [15:0]       id_imm16,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic              id_valid,
   input  logic [DATA_W-1:0] rf_rdata1,
   input  logic [DATA_W-1:0] rf_rdata2,
   input  logic [REG_AW-1:0] wb_wreg,
   input  logic [DATA_W-1:0] wb_wdata,
   input  logic              wb_we,
   input  logic              stall_in,
   input  logic              flush_in,
   output logic [REG_AW-1:0] ex_rs,
   output logic [REG_AW-1:0] ex_rt,
   output logic [REG_AW-1:0] ex_rd,
   output logic [DATA_W-1:0] ex_a,
   output logic [DATA_W-1:0] ex_b,
   output logic [DATA_W-1:0] ex_imm,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic              ex_valid,
   output logic              hz_stall
);

   import mips_pipe_pkg::*;

   logic [REG_AW-1:0] rs_q, rt_q, rd_q;
   logic [DATA_W-1:0] a_q, b_q, imm_q;
   logic [CTRL_W-1:0] ctrl_q;
   logic              valid_q;

   logic [DATA_W-1:0] a_d, b_d, imm_d;
   logic [CTRL_W-1:0] ctrl_d;
   logic              hz;
   logic              bubble;
   logic              load;

   id_bypass #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW)
   ) u_bypass (
      .rs_i       (id_rs),
      .rt_i       (id_rt),
      .rdata1_i   (rf_rdata1),
      .rdata2_i   (rf_rdata2),
      .wb_wreg_i  (wb_wreg),
      .wb_wdata_i (wb_wdata),
      .wb_we_i    (wb_we),
      .a_o        (a_d),
      .b_o        (b_d)
   );

   // Load in EX feeding a source of the instruction in ID.
   always_comb begin
      hz = valid_q && ctrl_q[MEM_READ] && (rt_q != '0) && id_valid &&
           ((rt_q == id_rs) || ((rt_q == id_rt) && id_ctrl[USES_RT]));
   end

   // Next-state payload and update selection.
   always_comb begin
      imm_d  = {{(DATA_W-16){id_imm16[15]}}, id_imm16};
      ctrl_d = id_ctrl & {CTRL_W{id_valid}};
      bubble = flush_in || (!stall_in && hz);
      load   = !flush_in && !stall_in && !hz;
   end

   // EX register: flush > stall > hazard bubble > normal load.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rs_q    <= '0;
         rt_q    <= '0;
         rd_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         imm_q   <= '0;
         ctrl_q  <= NOP_CTRL;
         valid_q <= 1'b0;
      end else if (bubble) begin
         rs_q    <= '0;
         rt_q    <= '0;
         rd_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         imm_q   <= '0;
         ctrl_q  <= NOP_CTRL;
         valid_q <= 1'b0;
      end else if (load) begin
         rs_q    <= id_rs;
         rt_q    <= id_rt;
         rd_q    <= id_rd;
         a_q     <= a_d;
         b_q     <= b_d;
         imm_q   <= imm_d;
         ctrl_q  <= ctrl_d;
         valid_q <= id_valid;
      end
   end

   assign ex_rs    = rs_q;
   assign ex_rt    = rt_q;
   assign ex_rd    = rd_q;
   assign ex_a     = a_q;
   assign ex_b     = b_q;
   assign ex_imm   = imm_q;
   assign ex_ctrl  = ctrl_q;
   assign ex_valid = valid_q;
   assign hz_stall = hz;

endmodule
